fifo36_verify_arb: RTL and testbench

- Packet-atomic round-robin arbiter that shares one 36-bit fifo36 verification datapath (fifo36-to-ll8 converter plus packet checker) among four fifo36 sources.
- Grants one source per packet, passes it through unmodified, and releases the grant on EOF or on a mid-packet stall timeout.
- Sits between up to four test/loopback streams and a single packet_verifier32 instance in the FPGA test fabric.

---
 rtl/fifo36_verify_arb_pkg.sv | 10 +
 rtl/fifo36_verify_arb_rr_pick4.sv | 19 +
 rtl/fifo36_verify_arb.sv | 119 +++++++++++
 tb/tb_fifo36_verify_arb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo36_verify_arb_pkg.sv
// fifo36_verify_arb_pkg: fifo36 field positions and arbiter FSM encoding shared by the arbiter files
package fifo36_verify_arb_pkg;
    localparam int FIFO36_W       = 36;
    localparam int FIFO36_SOF_BIT = 32;
    localparam int FIFO36_EOF_BIT = 33;
    localparam int FIFO36_OCC_LSB = 34;
    localparam int FIFO36_OCC_MSB = 35;
    localparam int NPORTS         = 4;
    typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;
endpackage

// File: rtl/fifo36_verify_arb_rr_pick4.sv
// rr_pick4: rotating-priority encoder, first set request at or after ptr (mod 4)
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       gnt_any
);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    // rotate so the pointer position is bit 0, then take the lowest set bit
    always_comb begin
        dbl     = {req, req} >> ptr;
        rot     = dbl[3:0];
        off     = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        gnt_idx = ptr + off;
        gnt_any = |req;
    end
endmodule

// File: rtl/fifo36_verify_arb.sv
// fifo36_verify_arb: packet-atomic round-robin arbiter of four fifo36 sources onto one verifier
// Optional per-port EOF statistics when FIFO36_VERIFY_ARB_STATS_EN is defined.
module fifo36_verify_arb
    import fifo36_verify_arb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic [3:0]   enable_mask,
    input  logic [143:0] data_i,
    input  logic [3:0]   src_rdy_i,
    output logic [3:0]   dst_rdy_o,
    output logic [35:0]  data_o,
    output logic         src_rdy_o,
    input  logic         dst_rdy_i,
    output logic         grant_valid,
    output logic [1:0]   grant_port,
    output logic         timeout_pulse,
    output logic [15:0]  timeout_cnt,
    input  logic [1:0]   stat_sel,
    output logic [31:0]  stat_o
);
    state_t      state, state_nxt;
    logic [1:0]  rr_ptr, pick_idx;
    logic        pick_any, hold, sel_rdy, eof_xfer, expire;
    logic [15:0] stall_cnt, stall_nxt;
    logic [35:0] words [NPORTS];
    logic [35:0] sel_word;

    for (genvar g = 0; g < NPORTS; g++) begin : g_words
        assign words[g] = data_i[FIFO36_W*g +: FIFO36_W];
    end

    rr_pick4 u_pick (
        .req     (src_rdy_i & enable_mask),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // zero-latency pass-through of the granted port, watchdog and next-state decode
    always_comb begin
        hold                  = state == ST_HOLD;
        sel_word              = words[grant_port];
        sel_rdy               = src_rdy_i[grant_port];
        data_o                = hold ? sel_word : '0;
        src_rdy_o             = hold & sel_rdy;
        dst_rdy_o             = '0;
        dst_rdy_o[grant_port] = hold & dst_rdy_i;
        eof_xfer              = src_rdy_o & dst_rdy_i & sel_word[FIFO36_EOF_BIT];
        stall_nxt             = sel_rdy ? 16'd0 : stall_cnt + 16'd1;
        expire                = hold && TIMEOUT != 16'd0 && stall_nxt == TIMEOUT;
        grant_valid           = hold;
        state_nxt             = state;
        if (!hold && pick_any)
            state_nxt = ST_HOLD;
        if (hold && (eof_xfer || expire))
            state_nxt = ST_IDLE;
    end

    // FSM state register; clear truncates any packet in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else if (clear)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // grant bookkeeping, round-robin pointer and watchdog counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr        <= 2'd0;
            grant_port    <= 2'd0;
            stall_cnt     <= 16'd0;
            timeout_pulse <= 1'b0;
            timeout_cnt   <= 16'd0;
        end else if (clear) begin
            rr_ptr        <= 2'd0;
            stall_cnt     <= 16'd0;
            timeout_pulse <= 1'b0;
            timeout_cnt   <= 16'd0;
        end else begin
            timeout_pulse <= expire;
            stall_cnt     <= hold ? stall_nxt : 16'd0;
            if (!hold && pick_any)
                grant_port <= pick_idx;
            if (eof_xfer || expire)
                rr_ptr <= grant_port + 2'd1;
            if (expire && timeout_cnt != 16'hFFFF)
                timeout_cnt <= timeout_cnt + 16'd1;
        end
    end

`ifdef FIFO36_VERIFY_ARB_STATS_EN
    logic [31:0] eof_cnt [NPORTS];
    // per-port EOF transfer counters with a registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPORTS; i++) eof_cnt[i] <= '0;
            stat_o <= '0;
        end else if (clear) begin
            for (int i = 0; i < NPORTS; i++) eof_cnt[i] <= '0;
            stat_o <= '0;
        end else begin
            stat_o <= eof_cnt[stat_sel];
            if (eof_xfer)
                eof_cnt[grant_port] <= eof_cnt[grant_port] + 32'd1;
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_o          = '0;
`endif
endmodule

// File: tb/tb_fifo36_verify_arb.sv
// tb_fifo36_verify_arb: scoreboard bench with a behavioural arbitration model and random traffic
module tb_fifo36_verify_arb;
    localparam logic [15:0] TO = 16'd4;
    typedef struct {logic [35:0] w; int gap;} item_t;

    logic clk = 0, reset_n, clear = 0, src_rdy_o, dst_rdy_i = 0, grant_valid, timeout_pulse;
    logic [3:0] enable_mask = 4'hF, src_rdy_i = 0, dst_rdy_o;
    logic [143:0] data_i = '0;
    logic [35:0] data_o;
    logic [1:0] grant_port, stat_sel = 0;
    logic [15:0] timeout_cnt;
    logic [31:0] stat_o;

    int total = 0, bad = 0;
    item_t srcq [4][$];
    logic [35:0] expq [$];
    int dst_mode = 1;
    bit clr_req = 0, run = 0;
    bit moved [4] = '{default: 0};

    bit m_hold = 0, m_pulse = 0;
    int m_port = 0, m_ptr = 0, m_stall = 0, m_tcnt = 0;
    int m_eofs [4] = '{default: 0};
    logic [31:0] exp_stat = 0;

    fifo36_verify_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable_mask(enable_mask),
        .data_i(data_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o), .data_o(data_o),
        .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i), .grant_valid(grant_valid),
        .grant_port(grant_port), .timeout_pulse(timeout_pulse), .timeout_cnt(timeout_cnt),
        .stat_sel(stat_sel), .stat_o(stat_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at %0t: actual=%h required=%h", n, $time, a, e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_pkt(input int p, input int len, input int gmax);
        item_t it;
        for (int i = 0; i < len; i++) begin
            it.w = {2'($urandom), i == len - 1, i == 0, 32'($urandom)};
            it.gap = (gmax == 0 || $urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, gmax);
            srcq[p].push_back(it);
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() + expq.size() > 0 || m_hold) && n < max) begin
            cyc(1);
            n++;
        end
        if (n >= max) begin
            total++;
            bad++;
            $display("FAIL drain: traffic still pending after %0d cycles", max);
        end
    endtask

    // reference: one cycle of the arbitration rules, checked against DUT outputs
    task automatic model_step();
        logic [35:0] w;
        logic [3:0] req, ed;
        bit s, x;
        int p;
        w = data_i[36*m_port +: 36];
        s = m_hold && src_rdy_i[m_port];
        x = s && dst_rdy_i;
        ed = '0;
        if (m_hold && dst_rdy_i) ed[m_port] = 1'b1;
        chk("grant_valid", grant_valid, m_hold);
        chk("grant_port", grant_port, m_port);
        chk("src_rdy_o", src_rdy_o, s);
        chk("dst_rdy_o", dst_rdy_o, ed);
        chk("data_o", data_o, m_hold ? w : 36'h0);
        chk("timeout_pulse", timeout_pulse, m_pulse);
        chk("timeout_cnt", timeout_cnt, m_tcnt);
        chk("stat_o", stat_o, exp_stat);
        if (x) expq.push_back(w);
`ifdef FIFO36_VERIFY_ARB_STATS_EN
        exp_stat = clear ? 32'd0 : 32'(m_eofs[stat_sel]);
`endif
        m_pulse = 0;
        if (clear) begin
            m_hold = 0; m_ptr = 0; m_stall = 0; m_tcnt = 0;
            m_eofs = '{default: 0};
        end else if (!m_hold) begin
            req = src_rdy_i & enable_mask;
            for (int i = 0; i < 4; i++) begin
                p = (m_ptr + i) % 4;
                if (!m_hold && req[p]) begin
                    m_hold = 1; m_port = p; m_stall = 0;
                end
            end
        end else begin
            m_stall = src_rdy_i[m_port] ? 0 : m_stall + 1;
            if (x && w[33]) begin
                m_hold = 0; m_ptr = (m_port + 1) % 4; m_eofs[m_port]++;
            end else if (TO != 0 && m_stall == int'(TO)) begin
                m_hold = 0; m_ptr = (m_port + 1) % 4; m_pulse = 1;
                if (m_tcnt < 65535) m_tcnt++;
            end
        end
    endtask

    // sources and the reference model advance on the falling edge
    initial begin
        item_t h;
        wait (run);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (moved[k]) void'(srcq[k].pop_front());
            clear = clr_req;
            clr_req = 0;
            for (int k = 0; k < 4; k++) begin
                if (srcq[k].size() > 0) begin
                    h = srcq[k][0];
                    data_i[36*k +: 36] = h.w;
                    src_rdy_i[k] = h.gap == 0;
                    if (h.gap > 0) begin
                        h.gap--;
                        srcq[k][0] = h;
                    end
                end else begin
                    data_i[36*k +: 36] = '0;
                    src_rdy_i[k] = 1'b0;
                end
            end
            dst_rdy_i = dst_mode == 2 ? ($urandom_range(0, 3) != 0) : (dst_mode == 1);
            #1;
            model_step();
            for (int k = 0; k < 4; k++) moved[k] = src_rdy_i[k] & dst_rdy_o[k];
        end
    end

    // monitor: every beat the DUT delivers must match the next expected word
    initial begin
        logic [35:0] e;
        wait (run);
        forever begin
            @(negedge clk);
            #2;
            if (src_rdy_o && dst_rdy_i) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat: actual=%h required=no beat", data_o);
                end else begin
                    e = expq.pop_front();
                    chk("beat", data_o, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        item_t it;
        reset_n = 1;
        #1 reset_n = 0;
        #2;
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_port", grant_port, 0);
        chk("rst_src_rdy_o", src_rdy_o, 0);
        chk("rst_dst_rdy_o", dst_rdy_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_timeout_pulse", timeout_pulse, 0);
        chk("rst_timeout_cnt", timeout_cnt, 0);
        chk("rst_stat_o", stat_o, 0);
        @(negedge clk);
        reset_n = 1;
        run = 1;
        cyc(2);
        // alternating ports 0 and 2
        repeat (2) begin
            add_pkt(0, 3, 0);
            add_pkt(2, 3, 0);
        end
        drain(200);
        // port 1 packet must not be interleaved with port 3
        add_pkt(1, 5, 0);
        cyc(3);
        add_pkt(3, 3, 0);
        drain(200);
        // watchdog release on port 0, port 1 next
        it.w = {2'd0, 2'b01, 32'hA0A0_0001}; it.gap = 0;  srcq[0].push_back(it);
        it.w = {2'd0, 2'b00, 32'hA0A0_0002}; it.gap = 10; srcq[0].push_back(it);
        it.w = {2'd0, 2'b10, 32'hA0A0_0003}; it.gap = 0;  srcq[0].push_back(it);
        add_pkt(1, 2, 0);
        drain(200);
        chk("timeout_cnt_after_stall", timeout_cnt, 1);
        // long backpressure is not a stall
        dst_mode = 0;
        add_pkt(2, 3, 0);
        cyc(100);
        chk("bp_grant_held", grant_valid, 1);
        dst_mode = 1;
        drain(200);
        chk("timeout_cnt_after_bp", timeout_cnt, 1);
        // clear in the middle of a port 2 packet
        enable_mask = 4'b0100;
        add_pkt(2, 6, 0);
        add_pkt(1, 2, 0);
        add_pkt(3, 2, 0);
        cyc(4);
        enable_mask = 4'hF;
        clr_req = 1;
        cyc(2);
        chk("clear_grant_port", grant_port, 1);
        drain(300);
`ifdef FIFO36_VERIFY_ARB_STATS_EN
        clr_req = 1;
        cyc(2);
        stat_sel = 2'd3;
        repeat (7) add_pkt(3, 2, 0);
        drain(300);
        cyc(2);
        chk("stat_port3", stat_o, 32'd7);
        stat_sel = 2'd0;
        cyc(2);
        chk("stat_port0", stat_o, 32'd0);
`endif
        // random traffic with stalls, backpressure and mask changes
        dst_mode = 2;
        repeat (30) begin
            add_pkt($urandom_range(0, 3), $urandom_range(1, 5), 6);
            add_pkt($urandom_range(0, 3), $urandom_range(1, 5), 6);
            enable_mask = 4'($urandom_range(1, 15));
            stat_sel = 2'($urandom);
            cyc($urandom_range(3, 12));
        end
        enable_mask = 4'hF;
        drain(5000);
        cyc(3);
        chk("scoreboard_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
